// File: rtl/booth_pkg.sv
// Shared types and sizing helpers for the radix-4 Booth multiplier.
// Optional feature macro: BOOTH_R4_EARLY_TERM_EN (see booth_r4_mult.sv).
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    ZERO = 3'd0,
    P1   = 3'd1,
    P2   = 3'd2,
    M1   = 3'd3,
    M2   = 3'd4
  } digit_t;

  localparam int CNT_W = 8;

  // One spare bit for the sign of unsigned operands, rounded up to a whole digit pair.
  function automatic int ext_width(input int width);
    return (((width + 1) % 2) == 0) ? (width + 1) : (width + 2);
  endfunction

  function automatic int n_iter(input int width);
    return ext_width(width) / 2;
  endfunction

endpackage

// File: rtl/booth_r4_enc.sv
// Radix-4 Booth recoder: multiplier triplet to signed digit and the matching
// EW+1 bit two's-complement addend (0, +-A, +-2A).
module booth_r4_enc
  import booth_pkg::*;
#(
  parameter int EW = 10
) (
  input  logic [2:0]  i_triplet,
  input  logic [EW-1:0] i_a,
  output digit_t      o_digit,
  output logic [EW:0] o_addend
);

  logic [EW:0] w_a1;
  logic [EW:0] w_a2;
  logic [EW:0] w_a1_neg;
  logic [EW:0] w_a2_neg;

  assign w_a1     = {i_a[EW-1], i_a};
  assign w_a2     = {i_a, 1'b0};
  assign w_a1_neg = ~w_a1 + {{EW{1'b0}}, 1'b1};
  assign w_a2_neg = ~w_a2 + {{EW{1'b0}}, 1'b1};

  // Digit selection followed by addend formation.
  always_comb begin
    o_digit  = ZERO;
    o_addend = {(EW+1){1'b0}};
    case (i_triplet)
      3'b000, 3'b111: o_digit = ZERO;
      3'b001, 3'b010: o_digit = P1;
      3'b011:         o_digit = P2;
      3'b100:         o_digit = M2;
      3'b101, 3'b110: o_digit = M1;
      default:        o_digit = ZERO;
    endcase
    case (o_digit)
      ZERO:    o_addend = {(EW+1){1'b0}};
      P1:      o_addend = w_a1;
      P2:      o_addend = w_a2;
      M1:      o_addend = w_a1_neg;
      M2:      o_addend = w_a2_neg;
      default: o_addend = {(EW+1){1'b0}};
    endcase
  end

endmodule

// File: rtl/booth_r4_mult.sv
// Sequential radix-4 Booth multiplier with start/busy/done handshake.
// Define BOOTH_R4_EARLY_TERM_EN to stop as soon as the remaining multiplier bits are uniform.
module booth_r4_mult
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [7:0]         digits
);

  localparam int EW    = ext_width(WIDTH);
  localparam int NITER = n_iter(WIDTH);

  state_t             r_state;
  logic [EW-1:0]      r_a;
  logic [2*EW-1:0]    r_acc;
  logic [EW:0]        r_mult;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy;
  logic               r_done;
  logic [2*WIDTH-1:0] r_product;
  logic [7:0]         r_digits;

  logic [EW-1:0]      w_a_ext;
  logic [EW-1:0]      w_b_ext;
  digit_t             w_digit;
  logic [EW:0]        w_addend;
  logic [2*EW-1:0]    w_addend_ext;
  logic [2*EW-1:0]    w_shifted;
  logic [2*EW-1:0]    w_acc_next;
  logic               w_term;

  assign w_a_ext = is_signed ? {{(EW-WIDTH){a[WIDTH-1]}}, a} : {{(EW-WIDTH){1'b0}}, a};
  assign w_b_ext = is_signed ? {{(EW-WIDTH){b[WIDTH-1]}}, b} : {{(EW-WIDTH){1'b0}}, b};

  booth_r4_enc #(.EW(EW)) u_enc (
    .i_triplet (r_mult[2:0]),
    .i_a       (r_a),
    .o_digit   (w_digit),
    .o_addend  (w_addend)
  );

  // Digit i carries weight 4^i, so the addend is shifted by twice the digit index.
  assign w_addend_ext = {{(EW-1){w_addend[EW]}}, w_addend};
  assign w_shifted    = w_addend_ext << {r_cnt, 1'b0};
  assign w_acc_next   = (w_digit == ZERO) ? r_acc : (r_acc + w_shifted);

`ifdef BOOTH_R4_EARLY_TERM_EN
  assign w_term = (&r_mult) | ~(|r_mult);
`else
  assign w_term = 1'b0;
`endif

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_a       <= {EW{1'b0}};
      r_acc     <= {(2*EW){1'b0}};
      r_mult    <= {(EW+1){1'b0}};
      r_cnt     <= {CNT_W{1'b0}};
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_product <= {(2*WIDTH){1'b0}};
      r_digits  <= 8'd0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= w_a_ext;
            r_acc   <= {(2*EW){1'b0}};
            r_mult  <= {w_b_ext, 1'b0};
            r_cnt   <= {CNT_W{1'b0}};
            r_busy  <= 1'b1;
            r_state <= CALC;
          end else begin
            r_state <= IDLE;
          end
        end
        CALC: begin
          if (w_term) begin
            r_state <= DONE;
          end else begin
            r_acc  <= w_acc_next;
            r_mult <= {{2{r_mult[EW]}}, r_mult[EW:2]};
            r_cnt  <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            if (r_cnt == CNT_W'(NITER - 1)) begin
              r_state <= DONE;
            end else begin
              r_state <= CALC;
            end
          end
        end
        DONE: begin
          r_product <= r_acc[2*WIDTH-1:0];
          r_digits  <= r_cnt;
          r_done    <= 1'b1;
          r_busy    <= 1'b0;
          r_state   <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign product = r_product;
  assign digits  = r_digits;

endmodule

// File: tb/tb_booth_r4_mult.sv
// Self-checking bench for booth_r4_mult (WIDTH=8): directed table, handshake
// corner sequences and a random sweep against an arithmetic reference.
module tb_booth_r4_mult;

  localparam int W     = 8;
  localparam int NITER = 5;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic           is_signed;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;
  logic [7:0]     digits;

  int errors = 0;
  int checks = 0;
  logic [2*W-1:0] last_prod;

  booth_r4_mult #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .is_signed (is_signed),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .product   (product),
    .digits    (digits)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic         sg;
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic [15:0]  prod;
    int           dig_n;
    int           lat_n;
    int           dig_e;
    int           lat_e;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic longint ext(input logic [W-1:0] v, input logic sg);
    if (sg) return longint'($signed(v));
    else    return longint'({56'd0, v});
  endfunction

  function automatic logic [15:0] ref_prod(input logic [W-1:0] x, input logic [W-1:0] y, input logic sg);
    longint p;
    p = ext(x, sg) * ext(y, sg);
    return p[15:0];
  endfunction

  // Digits needed until the rest of the recoded multiplier is all-0 or all-1.
  function automatic int ref_digits(input logic [W-1:0] y, input logic sg);
`ifdef BOOTH_R4_EARLY_TERM_EN
    longint m;
    longint r;
    m = ext(y, sg) * 2;
    for (int k = 0; k < NITER; k++) begin
      r = m >>> (2 * k);
      if (r == 0 || r == -1) return k;
    end
    return NITER;
`else
    return NITER;
`endif
  endfunction

  function automatic int ref_lat(input int dig);
    return (dig == NITER) ? (NITER + 1) : (dig + 2);
  endfunction

  task automatic run_op(input string nm, input logic sg, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [15:0] exp_p, input int exp_d, input int exp_l);
    int lat;
    bit got;
    @(negedge clk);
    is_signed = sg; a = x; b = y; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = ~x; b = ~y; is_signed = ~sg;
    chk({nm, "_busy_rise"}, busy, 1);
    chk({nm, "_done_low"}, done, 0);
    chk({nm, "_prod_held"}, product, last_prod);
    lat = 0; got = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = c; got = 1'b1;
        break;
      end
    end
    chk({nm, "_done_seen"}, got, 1);
    chk({nm, "_latency"}, lat, exp_l);
    chk({nm, "_product"}, product, exp_p);
    chk({nm, "_digits"}, digits, exp_d);
    chk({nm, "_busy_fall"}, busy, 0);
    last_prod = exp_p;
  endtask

  initial begin
    int ndone;
    logic sg;
    logic [W-1:0] x;
    logic [W-1:0] y;
    int d;

    vecs[0] = '{1'b1, 8'h80, 8'h80, 16'h4000, 5, 6, 4, 6};
    vecs[1] = '{1'b0, 8'hFF, 8'hFF, 16'hFE01, 5, 6, 5, 6};
    vecs[2] = '{1'b1, 8'hFF, 8'hFF, 16'h0001, 5, 6, 1, 3};
    vecs[3] = '{1'b1, 8'h07, 8'hFD, 16'hFFEB, 5, 6, 2, 4};
    vecs[4] = '{1'b1, 8'h55, 8'h00, 16'h0000, 5, 6, 0, 2};
    vecs[5] = '{1'b0, 8'h80, 8'h02, 16'h0100, 5, 6, 2, 4};
    vecs[6] = '{1'b1, 8'h80, 8'h7F, 16'hC080, 5, 6, 4, 6};
    vecs[7] = '{1'b0, 8'h80, 8'h7F, 16'h3F80, 5, 6, 4, 6};

    rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; a = 8'h00; b = 8'h00;
    last_prod = 16'h0000;
    #23;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_product", product, 0);
    chk("reset_digits", digits, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
`ifdef BOOTH_R4_EARLY_TERM_EN
      run_op($sformatf("vec%0d", i), vecs[i].sg, vecs[i].va, vecs[i].vb, vecs[i].prod, vecs[i].dig_e, vecs[i].lat_e);
`else
      run_op($sformatf("vec%0d", i), vecs[i].sg, vecs[i].va, vecs[i].vb, vecs[i].prod, vecs[i].dig_n, vecs[i].lat_n);
`endif
    end

    // start held high through the whole operation with changing operands
    @(negedge clk);
    is_signed = 1'b1; a = 8'h07; b = 8'hFD; start = 1'b1;
    @(posedge clk);
    #1;
    a = 8'h11; b = 8'h22; is_signed = 1'b0;
    ndone = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (done) begin
        ndone++;
        start = 1'b0;
        break;
      end
      a = a + 8'h01;
    end
    chk("spam_product", product, 16'hFFEB);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    chk("spam_done_count", ndone, 1);
    chk("spam_idle_busy", busy, 0);
    last_prod = 16'hFFEB;

    // reset asserted in the middle of CALC
    @(negedge clk);
    is_signed = 1'b0; a = 8'hFF; b = 8'hFF; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_done", done, 0);
    chk("rst_mid_product", product, 0);
    chk("rst_mid_digits", digits, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    chk("rst_mid_no_done", ndone, 0);
    last_prod = 16'h0000;
    run_op("after_rst", 1'b0, 8'h12, 8'h34, 16'h03A8, ref_digits(8'h34, 1'b0), ref_lat(ref_digits(8'h34, 1'b0)));

    // random sweep, back-to-back, with uniform multipliers mixed in
    for (int i = 0; i < 1000; i++) begin
      sg = 1'($urandom_range(1, 0));
      x  = 8'($urandom);
      case ($urandom_range(7, 0))
        0:       y = 8'h00;
        1:       y = 8'hFF;
        2:       y = 8'h01;
        default: y = 8'($urandom);
      endcase
      d = ref_digits(y, sg);
      run_op($sformatf("rnd%0d", i), sg, x, y, ref_prod(x, y, sg), d, ref_lat(d));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
